// File: rtl/apb_fifo_pkg.sv
// Shared register offsets and bit positions for the APB FIFO completer.
package apb_fifo_pkg;

   localparam logic [1:0] OFS_STATUS = 2'd0;
   localparam logic [1:0] OFS_PUSH   = 2'd1;
   localparam logic [1:0] OFS_POP    = 2'd2;
   localparam logic [1:0] OFS_CTRL   = 2'd3;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_UNF     = 3;
   localparam int ST_CNT_LSB = 8;
   localparam int ST_CNT_MSB = 15;

   localparam int CTRL_FLUSH  = 0;
   localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO storage with head-of-queue lookahead; push-when-full and
// pop-when-empty requests are ignored here and reported by the caller.
module fifo_sync #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           rdata,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_count == '0);
   assign full      = (r_count == CW'(DEPTH));
   assign count     = r_count;
   assign rdata     = r_mem[r_rptr];
   assign w_do_push = push & ~full;
   assign w_do_pop  = pop & ~empty;

   always_ff @(posedge PCLK) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= wdata;
      end
   end

   // Pointers are AW bits wide, so wrap modulo DEPTH falls out naturally.
   always_ff @(posedge PCLK) begin
      if (PRESET || flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB completer exposing a FIFO through STATUS/PUSH/POP/CTRL word registers.
// Optional PSLVERR output is enabled by defining APB_FIFO_PSLVERR_EN.
module apb_fifo_slave
   import apb_fifo_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 0
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic [31:0] PADDR,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
`ifdef APB_FIFO_PSLVERR_EN
   output logic        PSLVERR,
`endif
   output logic        irq
);

   localparam int         CW = $clog2(DEPTH) + 1;
   localparam logic [2:0] WS = 3'(WAIT_STATES);

   logic          w_setup;
   logic          w_access;
   logic          w_done;
   logic [1:0]    w_ofs;
   logic          w_push;
   logic          w_pop;
   logic          w_wr_ctrl;
   logic          w_flush;
   logic          w_empty;
   logic          w_full;
   logic [CW-1:0] w_count;
   logic [31:0]   w_head;
   logic [31:0]   w_status;
   logic [31:0]   w_rdmux;
   logic          w_unused_paddr;

   logic [2:0]    r_wcnt;
   logic          r_ovf;
   logic          r_unf;
   logic          r_irq_en;
   logic          r_irq;

   assign w_setup        = PSEL & ~PENABLE;
   assign w_access       = PSEL & PENABLE;
   assign w_ofs          = PADDR[3:2];
   assign w_unused_paddr = ^{PADDR[31:4], PADDR[1:0]};

   // PREADY is masked by PRESET so a transfer cut by reset never completes.
   assign PREADY    = w_access & (r_wcnt == WS) & ~PRESET;
   assign w_done    = PREADY;
   assign w_push    = w_done &  PWRITE & (w_ofs == OFS_PUSH);
   assign w_pop     = w_done & ~PWRITE & (w_ofs == OFS_POP);
   assign w_wr_ctrl = w_done &  PWRITE & (w_ofs == OFS_CTRL);
   assign w_flush   = w_wr_ctrl & PWDATA[CTRL_FLUSH];

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_wcnt <= '0;
      end else if (w_setup) begin
         r_wcnt <= '0;
      end else if (w_access && (r_wcnt != WS)) begin
         r_wcnt <= r_wcnt + 3'd1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_flush) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
         end else begin
            if (w_push && w_full) begin
               r_ovf <= 1'b1;
            end
            if (w_pop && w_empty) begin
               r_unf <= 1'b1;
            end
         end
         if (w_wr_ctrl) begin
            r_irq_en <= PWDATA[CTRL_IRQ_EN];
         end
         r_irq <= r_irq_en & ~w_empty;
      end
   end

   assign irq = r_irq & ~PRESET;

   fifo_sync #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .push   (w_push),
      .wdata  (PWDATA),
      .pop    (w_pop),
      .flush  (w_flush),
      .rdata  (w_head),
      .empty  (w_empty),
      .full   (w_full),
      .count  (w_count)
   );

   always_comb begin
      w_status                         = '0;
      w_status[ST_EMPTY]               = w_empty;
      w_status[ST_FULL]                = w_full;
      w_status[ST_OVF]                 = r_ovf;
      w_status[ST_UNF]                 = r_unf;
      w_status[ST_CNT_MSB:ST_CNT_LSB]  = 8'(w_count);
   end

   always_comb begin
      w_rdmux = '0;
      case (w_ofs)
         OFS_STATUS: w_rdmux = w_status;
         OFS_POP:    w_rdmux = w_empty ? '0 : w_head;
         OFS_CTRL:   w_rdmux[CTRL_IRQ_EN] = r_irq_en;
         default:    w_rdmux = '0;
      endcase
   end

   assign PRDATA = (PSEL && !PRESET) ? w_rdmux : '0;

`ifdef APB_FIFO_PSLVERR_EN
   assign PSLVERR = w_done & ((w_push & w_full) | (w_pop & w_empty) |
                              (PWRITE & ((w_ofs == OFS_STATUS) | (w_ofs == OFS_POP))));
`endif

endmodule

// File: doc/apb_fifo_slave.md
Name: apb_fifo_slave

Overview:
- APB completer peripheral. Sits directly downstream of the APB manager on one PSELx slot.
- Exposes a DEPTH-entry, 32-bit synchronous FIFO through four word registers: status, push, pop and control.
- Supports configurable wait states and a level interrupt.
- Storage is a separate FIFO sub-module; this block owns APB decode, the handshake and the register semantics.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..128.
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion; 0..7.

Ports:
- PCLK  input  1  clock; all state updates on rising edge.
- PRESET  input  1  synchronous, active-high reset.
- PSEL  input  1  slave select from manager.
- PENABLE  input  1  access-phase indicator.
- PADDR  input  32  byte address; only PADDR[3:2] decoded, rest ignored.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data; valid when PREADY=1.
- PREADY  output  1  transfer completion.
- irq  output  1  registered level interrupt.

Behaviour:
- Register map:
  - 0x0 STATUS, RO: [0] empty, [1] full, [2] overflow (sticky), [3] underflow (sticky), [15:8] count; other bits 0.
  - 0x4 PUSH, WO: reads return 0.
  - 0x8 POP, RO: read returns head entry, or 0 if empty.
  - 0xC CTRL, RW: [0] flush (self-clearing, reads 0), [1] irq_en; other bits read 0.
- Handshake:
  - wcnt is reset to 0 in the setup phase (PSEL=1, PENABLE=0).
  - In access (PSEL=1, PENABLE=1) with wcnt != WAIT_STATES, wcnt increments.
  - PREADY = PSEL & PENABLE & (wcnt == WAIT_STATES), combinational from wcnt.
  - With WAIT_STATES=0, PREADY rises in the first access cycle.
  - Completion = PSEL & PENABLE & PREADY. All side effects happen only on the completion edge, exactly once per transfer.
- PRDATA: combinational mux of PADDR[3:2] while PSEL=1; 0 when PSEL=0.
- Writes:
  - PUSH when not full: enqueue PWDATA.
  - PUSH when full: data dropped, overflow set to 1.
  - CTRL: writing [0]=1 flushes the FIFO (count 0) and clears overflow/underflow in the same edge; [1] stores irq_en.
  - Writes to STATUS/POP have no effect.
- Reads:
  - POP when not empty: dequeue on completion; PRDATA shows the pre-pop head.
  - POP when empty: PRDATA=0, underflow set to 1, pointers unchanged.
  - Other reads have no side effect.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits, zero-extended into [15:8].
- irq is registered: irq <= irq_en & !empty, so it follows the FIFO state by one cycle.
- PRESET (synchronous, any point including mid-transfer):
  - FIFO emptied; sticky flags, irq_en and wcnt = 0.
  - PREADY=0, PRDATA=0, irq=0 while PRESET is high.
  - A transfer interrupted by reset produces no side effect.
- PSEL dropped mid-access without completion: no side effect; wcnt reloads at the next setup phase.

Optional Feature:
- Macro APB_FIFO_PSLVERR_EN.
- Defined: adds output PSLVERR (1 bit), asserted only in the completion cycle for:
  - PUSH when full;
  - POP when empty;
  - a write to STATUS or POP.
  - Sticky flags still update. PSLVERR=0 in reset and in every non-completion cycle.
- Undefined: no PSLVERR port; errors are reported only via the sticky flags.

Decomposition:
- Package apb_fifo_pkg:
  - register offset localparams OFS_STATUS=2'd0, OFS_PUSH=2'd1, OFS_POP=2'd2, OFS_CTRL=2'd3;
  - STATUS/CTRL bit-index constants.
- Sub-module fifo_sync (params DEPTH, WIDTH=32):
  - ports PCLK, PRESET, push, wdata, pop, flush, rdata (head, combinational), empty, full, count;
  - push when full and pop when empty are ignored inside fifo_sync.

Test Plan:
- Reset, then read 0x0 -> PRDATA=0x0000_0001 (empty), irq=0, PREADY high in first access cycle (WAIT_STATES=0).
- Push 0xDEAD_BEEF, 0x1234_5678 to 0x4, then read 0x0 -> 0x0000_0200; pop 0x8 twice -> 0xDEAD_BEEF then 0x1234_5678; status returns to 0x0000_0001.
- DEPTH=16: push 17 values -> STATUS=0x0000_1006 (full, overflow, count 16); 17th value never popped; write CTRL=0x1 -> STATUS=0x0000_0001.
- Pop when empty -> PRDATA=0, STATUS[3]=1; with APB_FIFO_PSLVERR_EN, PSLVERR=1 in that completion cycle only.
- WAIT_STATES=3: push -> PREADY low for 3 access cycles, high on the 4th; count increments exactly once.
- Write CTRL=0x2, push one word -> irq rises one cycle after the push completion edge; assert PRESET mid-access of a POP -> no dequeue, irq/PREADY=0, count=0.
